// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial sequence detector.
// Holds the reset-time default pattern, fill-width sizing and saturating increment.
package seq_det_pkg;

    localparam int         DEFAULT_PAT_W   = 6;
    localparam logic [5:0] DEFAULT_PATTERN = 6'b110101;

    // Fill counter must represent 0..pat_w inclusive.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Increment value, holding at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the match count; holds at 2^W-1.
// Widths up to 32 bits are supported by the shared increment helper.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (inc) begin
            cnt_next = W'(sat_inc(32'(cnt_reg), W));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/seq_detector_param.sv
// Serial sequence detector: compares the last PAT_W valid bits against a
// runtime-loadable pattern and emits a registered one-cycle match pulse.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = DEFAULT_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEFAULT_PATTERN),
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_in,
    input  logic             d_valid,
    input  logic             overlap_en,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             q_out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam int               FILL_W    = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  sr_reg, sr_next;
    logic [PAT_W-1:0]  pat_reg, pat_next;
    logic [FILL_W-1:0] fill_reg, fill_next;
    logic              q_reg, q_next;

    logic [PAT_W-1:0]  sr_shift;
    logic [PAT_W-1:0]  bit_eq;
    logic [FILL_W-1:0] fill_inc;
    logic              pattern_eq;
    logic              hit;

    // Oldest bit lives at the MSB; each bit also compares against its pattern slot.
    genvar gi;
    generate
        for (gi = 0; gi < PAT_W; gi++) begin : g_bits
            if (gi == 0) begin : g_lsb
                assign sr_shift[gi] = d_in;
            end else begin : g_upper
                assign sr_shift[gi] = sr_reg[gi-1];
            end
            assign bit_eq[gi] = ~(sr_shift[gi] ^ pat_reg[gi]);
        end
    endgenerate

    assign pattern_eq = &bit_eq;
    assign fill_inc   = (fill_reg == FILL_FULL) ? FILL_FULL : fill_reg + FILL_W'(1);
    assign hit        = d_valid && !pat_load && (fill_inc == FILL_FULL) && pattern_eq;

    always_comb begin
        sr_next   = sr_reg;
        pat_next  = pat_reg;
        fill_next = fill_reg;
        q_next    = 1'b0;
        if (pat_load) begin
            // A load restarts detection; the bit presented this cycle is dropped.
            pat_next  = pat_in;
            sr_next   = '0;
            fill_next = '0;
        end else if (d_valid) begin
            sr_next   = sr_shift;
            fill_next = (hit && !overlap_en) ? '0 : fill_inc;
            q_next    = hit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_reg   <= '0;
            pat_reg  <= PATTERN;
            fill_reg <= '0;
            q_reg    <= 1'b0;
        end else begin
            sr_reg   <= sr_next;
            pat_reg  <= pat_next;
            fill_reg <= fill_next;
            q_reg    <= q_next;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hit),
        .cnt   (match_cnt)
    );

    assign q_out = q_reg;
    assign armed = (fill_reg == FILL_FULL);

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench: default-sized detector plus a 2-bit-counter copy driven in lockstep.
// Expectations are queued as each cycle is driven and compared just after the edge.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       d_in = 1'b0;
    logic       d_valid = 1'b0;
    logic       overlap_en = 1'b1;
    logic       pat_load = 1'b0;
    logic [5:0] pat_in = 6'b0;

    logic       q_out, armed;
    logic [7:0] match_cnt;
    logic       q_out_s, armed_s;
    logic [1:0] match_cnt_s;

    always #5 clk = ~clk;

    seq_detector_param dut (
        .clk        (clk),
        .reset      (reset),
        .d_in       (d_in),
        .d_valid    (d_valid),
        .overlap_en (overlap_en),
        .pat_load   (pat_load),
        .pat_in     (pat_in),
        .q_out      (q_out),
        .match_cnt  (match_cnt),
        .armed      (armed)
    );

    seq_detector_param #(.CNT_W(2)) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .d_in       (d_in),
        .d_valid    (d_valid),
        .overlap_en (overlap_en),
        .pat_load   (pat_load),
        .pat_in     (pat_in),
        .q_out      (q_out_s),
        .match_cnt  (match_cnt_s),
        .armed      (armed_s)
    );

    typedef struct {
        logic       rst, dv, din, ov, pl;
        logic [5:0] pin;
        logic       q;
        int         cnt;
        logic       armed;
    } vec_t;

    typedef struct {
        logic  q;
        int    cnt;
        int    sat;
        logic  armed;
        string tag;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   step_no = 0;
    logic ov_mode = 1'b1;

    task automatic chk(input string name, input string tag, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s [%s] step %0d: got %0d, expected %0d", name, tag, step_no, act, exp_v);
    endtask

    task automatic step(input logic rst, input logic dv, input logic din, input logic pl,
                        input logic [5:0] pin, input logic eq, input int ecnt,
                        input logic earmed, input string tag);
        exp_t e;
        reset = rst; d_valid = dv; d_in = din; pat_load = pl; pat_in = pin;
        overlap_en = ov_mode;
        e.q = eq; e.cnt = ecnt; e.sat = (ecnt > 3) ? 3 : ecnt; e.armed = earmed; e.tag = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        e = sb_q.pop_front();
        chk("q_out", e.tag, int'(q_out), int'(e.q));
        chk("match_cnt", e.tag, int'(match_cnt), e.cnt);
        chk("armed", e.tag, int'(armed), int'(e.armed));
        chk("q_out_sat", e.tag, int'(q_out_s), int'(e.q));
        chk("match_cnt_sat", e.tag, int'(match_cnt_s), e.sat);
        $display("step %0d %s: rst=%0b dv=%0b din=%0b pl=%0b ov=%0b -> q=%0b cnt=%0d armed=%0b sat_cnt=%0d",
                 step_no, e.tag, rst, dv, din, pl, ov_mode, q_out, match_cnt, armed, match_cnt_s);
    endtask

    task automatic add(input logic rst, input logic dv, input logic din, input logic ov,
                       input logic pl, input logic [5:0] pin, input logic q, input int cnt,
                       input logic arm);
        vec_t v;
        v.rst = rst; v.dv = dv; v.din = din; v.ov = ov; v.pl = pl; v.pin = pin;
        v.q = q; v.cnt = cnt; v.armed = arm;
        tbl.push_back(v);
    endtask

    initial begin
        logic [5:0] seq;
        seq = 6'b110101;

        // Reset, then default pattern with overlap on.
        add(1, 0, 0, 1, 0, 6'h00, 0, 0, 0);
        add(1, 0, 0, 1, 0, 6'h00, 0, 0, 0);
        add(0, 1, 1, 1, 0, 6'h00, 0, 0, 0);
        add(0, 1, 1, 1, 0, 6'h00, 0, 0, 0);
        add(0, 1, 0, 1, 0, 6'h00, 0, 0, 0);
        add(0, 1, 1, 1, 0, 6'h00, 0, 0, 0);
        add(0, 1, 0, 1, 0, 6'h00, 0, 0, 0);
        add(0, 1, 1, 1, 0, 6'h00, 1, 1, 1);
        add(0, 0, 0, 1, 0, 6'h00, 0, 1, 1);
        // Pattern 101101 with overlap: hits on bits 6 and 9.
        add(0, 0, 0, 1, 1, 6'b101101, 0, 1, 0);
        add(0, 1, 1, 1, 0, 6'h00, 0, 1, 0);
        add(0, 1, 0, 1, 0, 6'h00, 0, 1, 0);
        add(0, 1, 1, 1, 0, 6'h00, 0, 1, 0);
        add(0, 1, 1, 1, 0, 6'h00, 0, 1, 0);
        add(0, 1, 0, 1, 0, 6'h00, 0, 1, 0);
        add(0, 1, 1, 1, 0, 6'h00, 1, 2, 1);
        add(0, 1, 1, 1, 0, 6'h00, 0, 2, 1);
        add(0, 1, 0, 1, 0, 6'h00, 0, 2, 1);
        add(0, 1, 1, 1, 0, 6'h00, 1, 3, 1);
        // Same stream without overlap: only bit 6 hits.
        add(0, 0, 0, 0, 1, 6'b101101, 0, 3, 0);
        add(0, 1, 1, 0, 0, 6'h00, 0, 3, 0);
        add(0, 1, 0, 0, 0, 6'h00, 0, 3, 0);
        add(0, 1, 1, 0, 0, 6'h00, 0, 3, 0);
        add(0, 1, 1, 0, 0, 6'h00, 0, 3, 0);
        add(0, 1, 0, 0, 0, 6'h00, 0, 3, 0);
        add(0, 1, 1, 0, 0, 6'h00, 1, 4, 0);
        add(0, 1, 1, 0, 0, 6'h00, 0, 4, 0);
        add(0, 1, 0, 0, 0, 6'h00, 0, 4, 0);
        add(0, 1, 1, 0, 0, 6'h00, 0, 4, 0);
        add(0, 0, 0, 0, 0, 6'h00, 0, 4, 0);

        foreach (tbl[i]) begin
            ov_mode = tbl[i].ov;
            step(tbl[i].rst, tbl[i].dv, tbl[i].din, tbl[i].pl, tbl[i].pin,
                 tbl[i].q, tbl[i].cnt, tbl[i].armed, "table");
        end

        // d_valid gaps between bits 3 and 4, d_in toggling while invalid.
        ov_mode = 1'b0;
        step(0, 0, 0, 1, 6'b110101, 0, 4, 0, "gap_load");
        step(0, 1, 1, 0, 6'h00, 0, 4, 0, "gap");
        step(0, 1, 1, 0, 6'h00, 0, 4, 0, "gap");
        step(0, 1, 0, 0, 6'h00, 0, 4, 0, "gap");
        step(0, 0, 0, 0, 6'h00, 0, 4, 0, "gap_idle");
        step(0, 0, 1, 0, 6'h00, 0, 4, 0, "gap_idle");
        step(0, 0, 0, 0, 6'h00, 0, 4, 0, "gap_idle");
        step(0, 1, 1, 0, 6'h00, 0, 4, 0, "gap");
        step(0, 1, 0, 0, 6'h00, 0, 4, 0, "gap");
        step(0, 1, 1, 0, 6'h00, 1, 5, 0, "gap_hit");
        step(0, 0, 0, 0, 6'h00, 0, 5, 0, "gap");

        // Saturation: five non-overlapping matches; 2-bit counter holds at 3.
        step(1, 0, 0, 0, 6'h00, 0, 0, 0, "sat_reset");
        for (int r = 1; r <= 5; r++) begin
            for (int b = 5; b >= 0; b--) begin
                step(0, 1, seq[b], 0, 6'h00, (b == 0), (b == 0) ? r : r - 1, 0, "sat");
            end
        end

        // Reset in the middle of a partial sequence.
        for (int b = 5; b >= 1; b--) step(0, 1, seq[b], 0, 6'h00, 0, 5, 0, "midrst_pre");
        step(1, 1, 1, 0, 6'h00, 0, 0, 0, "midrst_reset");
        step(0, 1, 1, 0, 6'h00, 0, 0, 0, "midrst_one");
        for (int b = 5; b >= 2; b--) step(0, 1, seq[b], 0, 6'h00, 0, 0, 0, "midrst");
        step(0, 1, seq[1], 0, 6'h00, 0, 0, 1, "midrst_full");
        step(0, 1, seq[0], 0, 6'h00, 1, 1, 0, "midrst_hit");

        // pat_load collides with a valid bit; the bit is dropped and fill restarts.
        for (int b = 5; b >= 1; b--) step(0, 1, seq[b], 0, 6'h00, 0, 1, 0, "coll_pre");
        step(0, 1, 1, 1, 6'b000111, 0, 1, 0, "coll_load");
        seq = 6'b000111;
        for (int b = 5; b >= 1; b--) step(0, 1, seq[b], 0, 6'h00, 0, 1, 0, "coll");
        step(0, 1, seq[0], 0, 6'h00, 1, 2, 0, "coll_hit");
        step(0, 0, 0, 0, 6'h00, 0, 2, 0, "coll_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
